// File: rtl/r_burst_scheduler.sv
// r_burst_scheduler: grants whole bursts round-robin to one shared r_width_converter, drives its header,
// and tags the converter's per-burst beat counts with the source that owned each burst.
module r_burst_scheduler #(
    parameter int         NUM_SRC   = 4,
    parameter int         SRC_W     = 2,
    parameter int         MAX_OUTST = 8,
    parameter logic [7:0] HDR_TAG   = 8'h5D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC*128-1:0] s_rdata,
    input  logic [NUM_SRC-1:0]     s_rlast,
    input  logic [NUM_SRC-1:0]     s_rvalid,
    output logic [NUM_SRC-1:0]     s_rready,
    output logic [127:0]           c_rdata,
    output logic                   c_rlast,
    output logic [23:0]            c_config,
    output logic                   c_valid,
    input  logic                   c_ready,
    input  logic [8:0]             c_num,
    input  logic                   c_num_valid,
    output logic                   c_num_ready,
    output logic [8:0]             cnt_num,
    output logic [SRC_W-1:0]       cnt_src,
    output logic                   cnt_valid,
    input  logic                   cnt_ready,
    output logic                   err_orphan
);
    // state | meaning
    // IDLE  | no burst owns the converter; arbitrate
    // BURST | granted source passed straight through until its last beat is accepted
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam int               PTR_W    = $clog2(MAX_OUTST);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(MAX_OUTST);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [SRC_W-1:0] SRC_ONE  = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);

    logic [0:0]       state;
    logic [SRC_W-1:0] gnt;
    logic [SRC_W-1:0] rr;
    logic [7:0]       seq;
    logic [SRC_W-1:0] fifo_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   inflight;

    logic             pick_found;
    logic [SRC_W-1:0] pick_idx;
    logic [SRC_W-1:0] cand;
    logic             fifo_nonempty;
    logic             push;
    logic             pop;
    logic             beat_last;

    // Scan from the farthest candidate back to rr so the nearest valid source wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = SRC_W'((int'(rr) + k) % NUM_SRC);
            if (s_rvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        c_rdata  = '0;
        c_rlast  = 1'b0;
        c_valid  = 1'b0;
        s_rready = '0;
        if (state == BURST) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (gnt == SRC_W'(i)) begin
                    c_rdata     = s_rdata[128*i +: 128];
                    c_rlast     = s_rlast[i];
                    c_valid     = s_rvalid[i];
                    s_rready[i] = c_ready;
                end
            end
        end
    end

    assign fifo_nonempty = (inflight != '0);
    assign cnt_num       = c_num;
    assign cnt_src       = fifo_mem[rd_ptr];
    assign cnt_valid     = c_num_valid & fifo_nonempty;
    // A count with nothing in flight is drained regardless of cnt_ready so it cannot stall the converter.
    assign c_num_ready   = fifo_nonempty ? cnt_ready : 1'b1;
    assign pop           = c_num_valid & cnt_ready & fifo_nonempty;
    assign push          = (state == IDLE) & pick_found & (inflight < FULL_CNT);
    assign beat_last     = c_valid & c_ready & c_rlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            rr         <= '0;
            seq        <= '0;
            c_config   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            inflight   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (push) begin
                    gnt      <= pick_idx;
                    c_config <= {seq, HDR_TAG, 8'(pick_idx)};
                    state    <= BURST;
                end
            end else if (beat_last) begin
                seq   <= seq + 8'd1;
                rr    <= (gnt == SRC_LAST) ? '0 : gnt + SRC_ONE;
                state <= IDLE;
            end

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      inflight <= inflight + CNT_ONE;
            else if (!push && pop) inflight <= inflight - CNT_ONE;

            if (c_num_valid && !fifo_nonempty) err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= pick_idx;
    end

endmodule
